// File: rtl/seq_div_12x6.sv
// Sequential restoring divider: DW-bit unsigned dividend by VW-bit unsigned divisor.
// One quotient bit per BUSY cycle, MSB first; divide-by-zero short-circuits to DONE.
module seq_div_12x6 #(
  parameter int unsigned DW = 12,
  parameter int unsigned VW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero
);

  localparam int unsigned CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [DW-1:0] dvd;      // dividend bits shift out MSB, quotient bits shift in LSB
  logic [VW-1:0] dsr;
  logic [VW:0]   pr;       // partial remainder
  logic [CW-1:0] cnt;

  logic [VW+1:0] trial;
  logic [VW:0]   pr_nxt;
  logic          qbit;

  // One restoring step: subtract divisor from {pr, next dividend bit}, restore on borrow
  always_comb begin
    trial  = {pr, dvd[DW-1]} - {2'b00, dsr};
    qbit   = ~trial[VW+1];
    pr_nxt = qbit ? trial[VW:0] : {pr[VW-1:0], dvd[DW-1]};
  end

  // Control FSM with datapath and registered handshake/result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      dvd       <= '0;
      dsr       <= '0;
      pr        <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            dvd      <= dividend;
            dsr      <= divisor;
            pr       <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            if (divisor == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
              div_zero  <= 1'b1;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          dvd <= {dvd[DW-2:0], qbit};
          pr  <= pr_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(DW - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= {dvd[DW-2:0], qbit};
            remainder <= pr_nxt[VW-1:0];
            div_zero  <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
